// File: rtl/scan_cmd_responder.sv
// Device-side command responder for the serial test link: decodes host command
// frames and drives the part's scan chain, primary inputs, clock and reset.
//
// Transmit handshake: tx_start is raised only while tx_ready=1, held until
// tx_ready is observed low, then dropped; the next byte or state change waits
// for tx_ready to return high.
module scan_cmd_responder #(
  parameter int NPI        = 8,
  parameter int NPO        = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_valid,
  input  logic [7:0]     rx_data,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  output logic           part_clk,
  output logic           part_rstn,
  output logic           part_se,
  output logic           part_tm,
  output logic           part_si,
  input  logic           part_so,
  output logic [NPI-1:0] part_pi,
  input  logic [NPO-1:0] part_po,
  output logic           busy,
  output logic [4:0]     dbg_state
);

  typedef enum logic [4:0] {
    IDLE, CNT_HI, CNT_LO, SET_WAIT, SHIFT_H, SHIFT_L, GET_SAMPLE, TX_REQ,
    TX_ACK, TX_DONE, EXEC_H, EXEC_L, FREE_H, FREE_L, RST_H, RST_L, MSG
  } state_t;

  localparam logic [7:0] C_R = 8'h72, C_S = 8'h73, C_G = 8'h67, C_I = 8'h69;
  localparam logic [7:0] C_O = 8'h6f, C_E = 8'h65, C_F = 8'h66, C_P = 8'h70;
  localparam logic [7:0] A_ONE = 8'h31, A_ZERO = 8'h30, A_QUEST = 8'h3f;
  localparam int OW = (NPO > 1) ? $clog2(NPO) : 1;

  state_t         state;
  logic [7:0]     cmd;
  logic [15:0]    count;
  logic [15:0]    o_idx;
  logic [NPO-1:0] po_snap;
  logic [1:0]     msg_idx;
  logic           stop_req;
  logic           rx_bit, rx_stop, po_bit, last;

  assign rx_bit    = (rx_data == A_ONE);
  assign rx_stop   = rx_valid && (rx_data == C_P);
  assign last      = (count == 16'd1);
  assign po_bit    = (32'(o_idx) < NPO) ? po_snap[o_idx[OW-1:0]] : 1'b0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  function automatic logic [7:0] msg_char(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h4f;
      2'd1:    return 8'h4b;
      default: return 8'h0a;
    endcase
  endfunction

  // X_H states hold part_clk low (data settles), X_L states hold it high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= '0;
      count     <= '0;
      o_idx     <= '0;
      po_snap   <= '0;
      msg_idx   <= '0;
      stop_req  <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      part_clk  <= 1'b0;
      part_rstn <= 1'b1;
      part_se   <= 1'b0;
      part_tm   <= 1'b0;
      part_si   <= 1'b0;
      part_pi   <= '0;
    end else begin
      case (state)
        IDLE: if (rx_valid) begin
          cmd <= rx_data;
          case (rx_data)
            C_S, C_G, C_I, C_O, C_E: state <= CNT_HI;
            C_F: begin stop_req <= 1'b0; state <= FREE_H; end
            C_R: begin part_rstn <= 1'b0; count <= 16'(RST_CYCLES); state <= RST_H; end
            C_P: state <= IDLE;
            default: begin tx_data <= A_QUEST; state <= TX_REQ; end
          endcase
        end
        CNT_HI: if (rx_valid) begin
          count[15:8] <= rx_data;
          state       <= CNT_LO;
        end
        CNT_LO: if (rx_valid) begin
          count[7:0] <= rx_data;
          if ({count[15:8], rx_data} == 16'd0) state <= IDLE;
          else begin
            case (cmd)
              C_S, C_I: state <= SET_WAIT;
              C_G:      begin part_tm <= 1'b1; state <= GET_SAMPLE; end
              C_O:      begin po_snap <= part_po; o_idx <= '0; state <= GET_SAMPLE; end
              default:  state <= EXEC_H;
            endcase
          end
        end
        SET_WAIT: if (rx_valid) begin
          if (cmd == C_S) begin
            part_si <= rx_bit;
            part_se <= 1'b1;
            part_tm <= 1'b1;
            state   <= SHIFT_H;
          end else begin
            part_pi <= {part_pi[NPI-2:0], rx_bit};
            count   <= count - 16'd1;
            if (last) state <= IDLE;
          end
        end
        SHIFT_H: begin part_clk <= 1'b1; state <= SHIFT_L; end
        SHIFT_L: begin
          part_clk <= 1'b0;
          count    <= count - 16'd1;
          if (last) begin
            part_se <= 1'b0;
            part_tm <= 1'b0;
            part_si <= 1'b0;
            state   <= IDLE;
          end else if (cmd == C_S) state <= SET_WAIT;
          else state <= GET_SAMPLE;
        end
        GET_SAMPLE: begin
          tx_data <= ((cmd == C_G) ? part_so : po_bit) ? A_ONE : A_ZERO;
          state   <= TX_REQ;
        end
        TX_REQ: if (tx_ready) begin tx_start <= 1'b1; state <= TX_ACK; end
        TX_ACK: if (!tx_ready) begin tx_start <= 1'b0; state <= TX_DONE; end
        TX_DONE: if (tx_ready) begin
          case (cmd)
            C_G: begin part_se <= 1'b1; part_si <= 1'b0; state <= SHIFT_H; end
            C_O: begin
              count <= count - 16'd1;
              o_idx <= o_idx + 16'd1;
              state <= last ? IDLE : GET_SAMPLE;
            end
            C_R: begin
              msg_idx <= msg_idx + 2'd1;
              state   <= (msg_idx == 2'd2) ? IDLE : MSG;
            end
            default: state <= IDLE;
          endcase
        end
        EXEC_H: begin part_clk <= 1'b1; state <= EXEC_L; end
        EXEC_L: begin
          part_clk <= 1'b0;
          count    <= count - 16'd1;
          state    <= last ? IDLE : EXEC_H;
        end
        // A stop seen while part_clk is high ends the run on this falling edge.
        FREE_H: begin
          part_clk <= 1'b1;
          if (rx_stop) stop_req <= 1'b1;
          state <= FREE_L;
        end
        FREE_L: begin
          part_clk <= 1'b0;
          state    <= (stop_req || rx_stop) ? IDLE : FREE_H;
        end
        RST_H: begin part_clk <= 1'b1; state <= RST_L; end
        RST_L: begin
          part_clk <= 1'b0;
          count    <= count - 16'd1;
          if (last) begin
            part_rstn <= 1'b1;
            msg_idx   <= 2'd0;
            state     <= MSG;
          end else state <= RST_H;
        end
        MSG: begin tx_data <= msg_char(msg_idx); state <= TX_REQ; end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
